// File: rtl/spi_master_if.sv
// Handshake and SPI pin bundle for spi_master; the master modport is the DUT side.
interface spi_master_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  hold_cs;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  done;
  logic                  busy;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  start, tx_data, hold_cs, miso,
    output rx_data, done, busy, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, hold_cs, miso,
    input  rx_data, done, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, CLK_DIV clk cycles per SCLK half-period.
// Define SPI_MASTER_BURST_EN to keep cs_n low between transfers via hold_cs.
module spi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus_io
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StTail,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  high_q, high_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  done_q, done_d;

`ifdef SPI_MASTER_BURST_EN
  logic                  hold_q, hold_d;
`else
  logic                  unused_hold_cs;
  assign unused_hold_cs = bus_io.hold_cs;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    high_d     = high_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
`ifdef SPI_MASTER_BURST_EN
    hold_d     = hold_q;
`endif

    unique case (state_q)
      StIdle, StHold: begin
        if (bus_io.start) begin
          state_d = StSetup;
          cnt_d   = '0;
          tx_d    = bus_io.tx_data;
`ifdef SPI_MASTER_BURST_EN
          hold_d  = bus_io.hold_cs;
        end else if ((state_q == StHold) && !bus_io.hold_cs) begin
          state_d = StIdle;
`else
        end else if (state_q == StHold) begin
          state_d = StIdle;
`endif
        end
      end

      StSetup: begin
        if (cnt_q == LastCnt) begin
          state_d = StXfer;
          cnt_d   = '0;
          bit_d   = '0;
          high_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StXfer: begin
        if (cnt_q == LastCnt) begin
          cnt_d  = '0;
          high_d = !high_q;
          if (high_q) begin
            // Sample at the end of the high phase; next bit appears as sclk falls.
            rx_shift_d = (rx_shift_q << 1) | DATA_WIDTH'(bus_io.miso);
            tx_d       = tx_q << 1;
          end else if (bit_q == LastBit) begin
            state_d = StTail;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StTail: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          rx_data_d = rx_shift_q;
          state_d   = StIdle;
`ifdef SPI_MASTER_BURST_EN
          if (hold_q) state_d = StHold;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      high_q     <= 1'b0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      high_q     <= high_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
`ifdef SPI_MASTER_BURST_EN
      hold_q     <= hold_d;
`endif
    end
  end

  // Pins decode straight from state so the async reset takes effect at once.
  assign bus_io.cs_n    = (state_q == StIdle);
  assign bus_io.busy    = (state_q == StSetup) || (state_q == StXfer) || (state_q == StTail);
  assign bus_io.sclk    = (state_q == StXfer) && high_q;
  assign bus_io.mosi    = (state_q != StIdle) && tx_q[DATA_WIDTH-1];
  assign bus_io.done    = done_q;
  assign bus_io.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DATA_WIDTH=8, CLK_DIV=4); burst checks follow SPI_MASTER_BURST_EN.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(8)) bus ();

  spi_master #(
    .DATA_WIDTH(8),
    .CLK_DIV   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave side: loopback or a mode-0 slave shifting slave_word out MSB first.
  logic       loopback   = 1'b1;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_q    = 8'h00;
  assign bus.miso = loopback ? bus.mosi : slave_q[7];

  logic       sclk_prev = 1'b0;
  int         n_rise    = 0;
  int         n_cslow   = 0;
  int         n_cshigh  = 0;
  int         n_done    = 0;
  int         n_bad     = 0;
  logic [7:0] mosi_hist = 8'h00;

  always @(negedge clk) begin
    sclk_prev <= bus.sclk;
    if (bus.sclk && !sclk_prev) begin
      n_rise    <= n_rise + 1;
      mosi_hist <= {mosi_hist[6:0], bus.mosi};
    end
    if (bus.cs_n) n_cshigh <= n_cshigh + 1;
    else          n_cslow  <= n_cslow + 1;
    if (bus.done) n_done <= n_done + 1;
    if (bus.cs_n && (bus.mosi || bus.sclk)) n_bad <= n_bad + 1;
    if (bus.cs_n)                    slave_q <= slave_word;
    else if (!bus.sclk && sclk_prev) slave_q <= slave_q << 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns at the negedge of the done cycle; done_at counts from the accepting cycle.
  task automatic xfer(input logic [7:0] tx, input logic hold, input bit poke, output int done_at);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = tx;
    bus.hold_cs = hold;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_data = ~tx;
    done_at = -1;
    for (int c = 1; c <= 200; c++) begin
      if (poke) begin
        bus.start = (c == 5) || (c == 40);
        bus.tx_data = 8'hFF;
      end
      if (bus.done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave;
    logic       loop;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, l0, d0, h0, da, db;

    vecs[0] = '{tx: 8'hA5, slave: 8'h00, loop: 1'b1, exp_rx: 8'hA5, exp_mosi: 8'hA5};
    vecs[1] = '{tx: 8'h00, slave: 8'h3C, loop: 1'b0, exp_rx: 8'h3C, exp_mosi: 8'h00};
    vecs[2] = '{tx: 8'hFF, slave: 8'h81, loop: 1'b0, exp_rx: 8'h81, exp_mosi: 8'hFF};
    vecs[3] = '{tx: 8'h5A, slave: 8'hC3, loop: 1'b0, exp_rx: 8'hC3, exp_mosi: 8'h5A};

    bus.start   = 1'b1;
    bus.tx_data = 8'hFF;
    bus.hold_cs = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cs_n", 32'(bus.cs_n), 32'd1);
    check("reset sclk", 32'(bus.sclk), 32'd0);
    check("reset mosi", 32'(bus.mosi), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset rx_data", 32'(bus.rx_data), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      loopback   = vecs[i].loop;
      slave_word = vecs[i].slave;
      r0 = n_rise;
      l0 = n_cslow;
      d0 = n_done;
      xfer(vecs[i].tx, 1'b0, 1'b0, da);
      check($sformatf("vec%0d done latency", i), 32'(da), 32'd73);
      check($sformatf("vec%0d rx_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d cs_n at done", i), 32'(bus.cs_n), 32'd1);
      check($sformatf("vec%0d busy at done", i), 32'(bus.busy), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d done width", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d rx_data hold", i), 32'(bus.rx_data), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d sclk pulses", i), 32'(n_rise - r0), 32'd8);
      check($sformatf("vec%0d mosi bits", i), 32'(mosi_hist), 32'(vecs[i].exp_mosi));
      check($sformatf("vec%0d cs_n low cycles", i), 32'(n_cslow - l0), 32'd72);
      check($sformatf("vec%0d done count", i), 32'(n_done - d0), 32'd1);
    end

    // Starts during a transfer are dropped, not queued.
    loopback   = 1'b0;
    slave_word = 8'h5A;
    d0 = n_done;
    xfer(8'hC3, 1'b0, 1'b1, da);
    check("busy-start latency", 32'(da), 32'd73);
    check("busy-start rx_data", 32'(bus.rx_data), 32'h5A);
    repeat (3) @(negedge clk);
    check("busy-start no restart", 32'(bus.busy), 32'd0);
    check("busy-start cs_n idle", 32'(bus.cs_n), 32'd1);
    check("busy-start done count", 32'(n_done - d0), 32'd1);

    // Async reset mid-transfer at cycle 30 (an sclk high phase).
    loopback = 1'b1;
    d0 = n_done;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = 8'h96;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 30; c++) @(negedge clk);
    check("abort sclk high before rst", 32'(bus.sclk), 32'd1);
    rst = 1'b1;
    #1;
    check("abort cs_n", 32'(bus.cs_n), 32'd1);
    check("abort sclk", 32'(bus.sclk), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort mosi", 32'(bus.mosi), 32'd0);
    check("abort rx_data", 32'(bus.rx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("abort no done", 32'(n_done - d0), 32'd0);
    r0 = n_rise;
    xfer(8'h96, 1'b0, 1'b0, da);
    check("post-abort latency", 32'(da), 32'd73);
    check("post-abort rx_data", 32'(bus.rx_data), 32'h96);
    @(negedge clk);
    check("post-abort sclk pulses", 32'(n_rise - r0), 32'd8);

`ifdef SPI_MASTER_BURST_EN
    d0 = n_done;
    xfer(8'h12, 1'b1, 1'b0, da);
    check("burst1 latency", 32'(da), 32'd73);
    check("burst1 rx_data", 32'(bus.rx_data), 32'h12);
    check("burst1 cs_n held", 32'(bus.cs_n), 32'd0);
    check("burst1 busy", 32'(bus.busy), 32'd0);
    h0 = n_cshigh;
    xfer(8'h34, 1'b0, 1'b0, db);
    check("burst2 latency", 32'(db), 32'd73);
    check("burst2 rx_data", 32'(bus.rx_data), 32'h34);
    check("burst cs_n never high", 32'(n_cshigh - h0), 32'd0);
    check("burst2 cs_n released", 32'(bus.cs_n), 32'd1);
    @(negedge clk);
    check("burst done count", 32'(n_done - d0), 32'd2);
    check("burst idle cs_n", 32'(bus.cs_n), 32'd1);
`else
    h0 = n_cshigh;
    xfer(8'h12, 1'b1, 1'b0, da);
    check("nohold latency", 32'(da), 32'd73);
    check("nohold rx_data", 32'(bus.rx_data), 32'h12);
    check("nohold cs_n at done", 32'(bus.cs_n), 32'd1);
    bus.hold_cs = 1'b1;
    @(negedge clk);
    check("nohold cs_n after", 32'(bus.cs_n), 32'd1);
    check("nohold busy after", 32'(bus.busy), 32'd0);
    check("nohold cs high seen", 32'(n_cshigh - h0 > 0), 32'd1);
    bus.hold_cs = 1'b0;
    db = 0;
`endif

    @(negedge clk);
    check("mosi/sclk quiet while deselected", 32'(n_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per transfer, MSB first.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range >= 2.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a transfer; sampled only when ready to accept.
REQ-006 tx_data  input  DATA_WIDTH  word to transmit, captured on the accepting cycle.
REQ-007 hold_cs  input  1  keep cs_n low after this transfer (burst mode only).
REQ-008 rx_data  output  DATA_WIDTH  last word received from miso.
REQ-009 done  output  1  one-cycle pulse, rx_data valid.
REQ-010 busy  output  1  transfer in progress.
REQ-011 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-012 mosi  output  1  master out, slave in.
REQ-013 miso  input  1  master in, slave out.
REQ-014 cs_n  output  1  active-low chip select.

Function
REQ-015 FSM states: IDLE, SETUP, XFER, TAIL, HOLD (HOLD reachable only with burst enabled).
REQ-016 IDLE: start=1 -> next cycle SETUP, busy=1, cs_n=0, mosi=tx_data[MSB], shift register loaded.
REQ-017 SETUP lasts CLK_DIV cycles, sclk=0, then XFER.
REQ-018 XFER lasts 2*DATA_WIDTH*CLK_DIV cycles; sclk high for the first CLK_DIV cycles of each bit, low for the next CLK_DIV.
REQ-019 miso sampled into the rx shift register on the last clk cycle of each sclk high phase.
REQ-020 mosi updated to the next bit on the first cycle of each sclk low phase; unchanged during the high phase.
REQ-021 TAIL lasts CLK_DIV cycles, sclk=0, cs_n=0.
REQ-022 After TAIL: done=1 for exactly one cycle, rx_data updated that same cycle, busy=0, cs_n=1 (or HOLD per REQ-032).
REQ-023 Latency: with start accepted at cycle 0, done asserts at cycle 1+CLK_DIV*(2*DATA_WIDTH+2).
REQ-024 start while busy=1 is ignored; no queuing.
REQ-025 start in the same cycle done is high is accepted only from IDLE/HOLD on the following cycle.
REQ-026 tx_data changes after acceptance do not affect the transfer in progress.
REQ-027 mosi=0 whenever cs_n=1; sclk=0 in every state except XFER high phases.
REQ-028 rx_data holds its value between done pulses.

Reset
REQ-029 rst=1 forces immediately: state IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, counters 0.
REQ-030 rst mid-transfer aborts with no done pulse; the first start after rst deassertion begins a fresh SETUP.

Configuration
REQ-031 Macro SPI_MASTER_BURST_EN selects burst support; hold_cs port present in both builds.
REQ-032 Defined: hold_cs sampled on the accepting cycle; if 1, after TAIL go to HOLD with cs_n=0, done pulsed, busy=0.
REQ-033 HOLD: start=1 -> SETUP without cs_n rising; start=0 and hold_cs=0 -> IDLE, cs_n=1 next cycle.
REQ-034 Undefined: hold_cs ignored, HOLD never entered, cs_n rises after every transfer.

Verification
REQ-035 CLK_DIV=4, start with tx_data=0xA5, loopback miso=mosi -> 8 sclk pulses, mosi 1,0,1,0,0,1,0,1, done at cycle 73, rx_data=0xA5.
REQ-036 Slave model drives 0x3C on miso, tx_data=0x00 -> rx_data=0x3C, cs_n low for exactly 72 cycles.
REQ-037 start pulsed at cycles 5 and 40 during transfer -> single done, no restart, second start ignored.
REQ-038 rst asserted at cycle 30 of a transfer -> cs_n=1, sclk=0 same cycle, no done; next start gives a correct full transfer.
REQ-039 BURST_EN, two starts with hold_cs=1 then 0, data 0x12,0x34 -> cs_n stays low across both, two done pulses, then cs_n=1.
REQ-040 No BURST_EN, hold_cs=1 -> cs_n returns high after done, identical to hold_cs=0.
